// File: rtl/func_sweep_ctrl.sv
// Clocked self-checking sweep sequencer for the funcDecoder block.
// Drives every select code in turn, samples the function outputs into a
// truth table and flags the first code whose sample differs from the
// expected table latched at start.
module func_sweep_ctrl #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned NFUNC  = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NFUNC*(2**SEL_W)-1:0]    exp_tt,
    input  logic [NFUNC-1:0]               f,
    output logic [SEL_W-1:0]               inp,
    output logic                           busy,
    output logic                           done,
    output logic [NFUNC*(2**SEL_W)-1:0]    tt,
    output logic                           err,
    output logic [SEL_W-1:0]               err_idx
);

    localparam int unsigned N     = 2 ** SEL_W;
    localparam int unsigned TT_W  = NFUNC * N;
    localparam int unsigned TT_AW = (TT_W > 1) ? $clog2(TT_W) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TT_W-1:0]    exp_q;
    logic [SEL_W-1:0]   inp_q;
    logic               busy_q;
    logic               done_q;
    logic [TT_W-1:0]    tt_q;
    logic               err_q;
    logic [SEL_W-1:0]   err_idx_q;

    logic [TT_W-1:0]    tt_d;
    logic               mism_d;
    logic [TT_AW-1:0]   bpos;

    // Table with the current code's column replaced by f, and the mismatch flag for that column
    always_comb begin
        tt_d   = tt_q;
        mism_d = 1'b0;
        bpos   = '0;
        for (int k = 0; k < int'(NFUNC); k++) begin
            bpos       = TT_AW'(k * int'(N) + int'(idx_q));
            tt_d[bpos] = f[k];
            if (f[k] != exp_q[bpos]) begin
                mism_d = 1'b1;
            end
        end
    end

    // Sweep sequencer: state, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            inp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tt_q      <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inp_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    // abort in the same cycle drops the start request
                    if (start && !abort) begin
                        idx_q     <= '0;
                        cnt_q     <= CNT_W'(SETTLE);
                        tt_q      <= '0;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        exp_q     <= exp_tt;
                        busy_q    <= 1'b1;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        inp_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        tt_q <= tt_d;
                        if (mism_d && !err_q) begin
                            err_q     <= 1'b1;
                            err_idx_q <= idx_q;
                        end
                        if (idx_q == SEL_W'(N - 1)) begin
                            inp_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + SEL_W'(1);
                            inp_q <= idx_q + SEL_W'(1);
                            cnt_q <= CNT_W'(SETTLE);
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    inp_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign inp     = inp_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign tt      = tt_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule
